// File: rtl/clock_time_counter.sv
// 24-hour BCD time-of-day counter with a CLK_HZ prescaler, set buttons,
// a seconds-clear pulse and a half-second colon blink output.
module clock_time_counter #(
    parameter int CLK_HZ = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       adv_min,
    input  logic       adv_hour,
    input  logic       clr_sec,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic [3:0] hour_ones,
    output logic [3:0] hour_tens,
    output logic       tick_1hz,
    output logic       colon
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_TOP  = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_HZ / 2);

    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    sec_ones_q, sec_ones_d, sec_tens_q, sec_tens_d;
    logic [3:0]    min_ones_q, min_ones_d, min_tens_q, min_tens_d;
    logic [3:0]    hour_ones_q, hour_ones_d, hour_tens_q, hour_tens_d;
    logic          tick_q, tick_d;
    logic          colon_q, colon_d;

    logic wrap, sec_adv, min_carry, hour_carry, min_step, hour_step;

    // Returns {tens, ones} of a BCD 00..59 value incremented modulo 60.
    function automatic logic [7:0] inc60(input logic [3:0] tens, input logic [3:0] ones);
        if (ones == 4'd9)
            return (tens == 4'd5) ? 8'h00 : {tens + 4'd1, 4'd0};
        return {tens, ones + 4'd1};
    endfunction

    function automatic logic [7:0] inc24(input logic [3:0] tens, input logic [3:0] ones);
        if (tens == 4'd2 && ones == 4'd3)
            return 8'h00;
        if (ones == 4'd9)
            return {tens + 4'd1, 4'd0};
        return {tens, ones + 4'd1};
    endfunction

    always_comb begin
        presc_d     = presc_q;
        sec_ones_d  = sec_ones_q;
        sec_tens_d  = sec_tens_q;
        min_ones_d  = min_ones_q;
        min_tens_d  = min_tens_q;
        hour_ones_d = hour_ones_q;
        hour_tens_d = hour_tens_q;

        wrap       = run && (presc_q == PRESC_TOP);
        sec_adv    = wrap && !clr_sec;
        min_carry  = sec_adv && (sec_tens_q == 4'd5) && (sec_ones_q == 4'd9);
        hour_carry = min_carry && (min_tens_q == 4'd5) && (min_ones_q == 4'd9);
        // Button and carry OR together so they never stack into a double step.
        min_step   = min_carry || adv_min;
        hour_step  = hour_carry || adv_hour;

        if (clr_sec || wrap)
            presc_d = '0;
        else if (run)
            presc_d = presc_q + PW'(1);

        if (clr_sec)
            {sec_tens_d, sec_ones_d} = 8'h00;
        else if (sec_adv)
            {sec_tens_d, sec_ones_d} = inc60(sec_tens_q, sec_ones_q);

        if (min_step)
            {min_tens_d, min_ones_d} = inc60(min_tens_q, min_ones_q);

        if (hour_step)
            {hour_tens_d, hour_ones_d} = inc24(hour_tens_q, hour_ones_q);

        tick_d  = sec_adv;
        // Derived from the next prescaler value so colon is aligned with it and holds when run=0.
        colon_d = (presc_d < PRESC_HALF);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q     <= '0;
            sec_ones_q  <= 4'd0;
            sec_tens_q  <= 4'd0;
            min_ones_q  <= 4'd0;
            min_tens_q  <= 4'd0;
            hour_ones_q <= 4'd0;
            hour_tens_q <= 4'd0;
            tick_q      <= 1'b0;
            colon_q     <= 1'b1;
        end else begin
            presc_q     <= presc_d;
            sec_ones_q  <= sec_ones_d;
            sec_tens_q  <= sec_tens_d;
            min_ones_q  <= min_ones_d;
            min_tens_q  <= min_tens_d;
            hour_ones_q <= hour_ones_d;
            hour_tens_q <= hour_tens_d;
            tick_q      <= tick_d;
            colon_q     <= colon_d;
        end
    end

    assign sec_ones  = sec_ones_q;
    assign sec_tens  = sec_tens_q;
    assign min_ones  = min_ones_q;
    assign min_tens  = min_tens_q;
    assign hour_ones = hour_ones_q;
    assign hour_tens = hour_tens_q;
    assign tick_1hz  = tick_q;
    assign colon     = colon_q;

endmodule
